if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Owns the architectural PC and is the fetch end of the next-PC interface.
- Consumes the next-PC target and redirect from the ID-stage next-PC calculator, returns the current PC and PC+4 to it, and drives the soc_sram instruction port.
- Presents a valid/allowin-handshaked instruction to ID.
- Handles MIPS delay slots, ID back-pressure (with instruction buffering), exception/ERET redirects and instruction-address-error detection.

Parameters:
- RESET_PC, 32'hbfc00000, first fetched address.
- EXC_VECTOR, 32'hbfc00380, exception entry address.
- ADEL_CODE, 5'h04, execode reported for a misaligned fetch.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_allowin  in  1  ID can accept an instruction this cycle
- id_is_branch  in  1  valid instruction currently in ID is a branch/jump
- npc_redirect  in  1  ID resolved a taken branch/jump this cycle
- npc_target  in  32  redirect target from the next-PC calculator
- exc_req  in  1  exception committed (from WB)
- exc_eret  in  1  ERET committed (from WB)
- epc  in  32  CP0 EPC
- inst_sram_en  out  1  instruction SRAM enable
- inst_sram_wen  out  4  constant 4'b0000
- inst_sram_addr  out  32  fetch address (next_pc)
- inst_sram_wdata  out  32  constant 0
- inst_sram_rdata  in  32  data for the address enabled in the previous cycle
- if_valid  out  1  IF holds a valid instruction for ID
- if_pc  out  32  PC of the IF instruction (to next-PC calculator and ID)
- if_four_pc  out  32  if_pc + 4
- if_inst  out  32  instruction word
- if_in_ds  out  1  IF instruction is a delay slot
- if_exc  out  1  fetch exception on this instruction
- if_execode  out  5  fetch execode
- if_badvaddr  out  32  faulting address

Behaviour:
- **State:** pc_q, valid_q, br_pend, br_tgt, buf_valid, inst_buf.
- **Reset values:** pc_q=RESET_PC-4, valid_q=0, br_pend=0, buf_valid=0, inst_buf=0.
  - While reset is high, inst_sram_en=0.
  - All if_* outputs are derived from this state, so if_valid=0 and if_exc=0 out of reset.
- **Handshake:**
  - advance = !valid_q || id_allowin.
  - The IF->ID transfer occurs when valid_q && id_allowin.
- **next_pc priority:**
  1. exc_req -> EXC_VECTOR
  2. exc_eret -> epc
  3. br_pend -> br_tgt
  4. npc_redirect -> npc_target
  5. otherwise pc_q+4
- **Redirect targets:**
  - Redirect targets (priorities 3 and 4) apply only when valid_q=1, i.e. the delay slot is leaving IF.
  - If valid_q=0, next_pc = pc_q+4, so the delay slot is fetched first.
- **Fetch enable:** inst_sram_en = !reset && (exc_req || exc_eret || advance); inst_sram_addr = next_pc.
- **Register update:** when en=1, pc_q<=next_pc and valid_q<=1 at the clock edge. Otherwise pc_q and valid_q hold.
- **Pending branch (br_pend/br_tgt):**
  - Set when npc_redirect=1 and the target was not consumed this cycle. The target is not consumed when advance=0, or when valid_q=0.
  - br_tgt <= npc_target on set. A repeated npc_redirect while pending rewrites br_tgt with the same value.
  - Cleared when consumed (advance with valid_q=1), on exc_req, and on exc_eret.
- **Instruction buffer:**
  - When valid_q && !id_allowin && !buf_valid: buf_valid<=1 and inst_buf<=inst_sram_rdata.
  - Cleared on any cycle where inst_sram_en=1.
  - if_inst = buf_valid ? inst_buf : inst_sram_rdata.
- **Delay slot flag:** if_in_ds = id_is_branch. It is meaningful only on the IF->ID transfer.
- **Address error:**
  - if_exc = valid_q && (pc_q[1:0]!=0).
  - if_execode = ADEL_CODE when if_exc, else 0.
  - if_badvaddr = pc_q.
  - if_inst forced to 0 (nop) when if_exc.
  - inst_sram_en is still asserted for a misaligned next_pc; the returned data is discarded via the forced nop.
- **Exception/ERET:**
  - Overrides stall, pending branch and redirect in the same cycle. br_pend and buf_valid are cleared.
  - The next cycle shows the vector (or EPC) instruction with valid_q=1.
  - exc_req together with exc_eret: exc_req wins.
- **Outputs:** if_valid=valid_q, if_pc=pc_q, if_four_pc=pc_q+4.
- **Arithmetic:** all PC arithmetic is 32-bit modulo; 32'hfffffffc+4 wraps to 0 without an error.
- **Reset mid-operation:** discards pending state next edge; the first fetch after reset is RESET_PC.

Test Plan:
1. Reset 3 cycles, then id_allowin=1 -> first edge: inst_sram_en=1, addr bfc00000. Next cycle: if_valid=1, if_pc=bfc00000. Subsequent addrs bfc00004, bfc00008.
2. Stall: id_allowin=0 for 3 cycles while if_pc=bfc00008, rdata changed after first stall cycle -> if_inst keeps the first word; en=0 during stall. On release, addr=bfc0000c.
3. Taken branch: if_pc=bfc00010 (delay slot), npc_redirect=1, npc_target=bfc00100, id_allowin=1 -> next if_pc=bfc00100; bfc00014 never fetched.
4. Branch under stall: npc_redirect pulse with id_allowin=0, then redirect deasserted, id_allowin=1 two cycles later -> br_pend holds bfc00100 and the fetch after the delay slot is bfc00100.
5. Exception: exc_req=1 while stalled with br_pend=1 -> en=1, addr bfc00380 regardless of id_allowin; br_pend and buf_valid cleared. exc_req+exc_eret together -> bfc00380.
6. ERET to epc=80000002 -> if_exc=1, if_execode=04, if_badvaddr=80000002, if_inst=0. Next addr 80000006.

Source files
------------

// File: rtl/if_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Instruction-fetch stage of a MIPS-style pipeline. Owns the
//                architectural PC, computes the next fetch address, drives the
//                instruction SRAM port and presents a valid/allowin handshaked
//                instruction to ID.
//
//                Branch redirects take effect only after the delay slot has
//                left IF. A redirect arriving while the delay slot is not yet
//                fetched, or while ID is stalling, is held in a pending-branch
//                register. When ID stalls, the returned SRAM word is captured
//                in a one-entry buffer, so the SRAM may be idle during the
//                stall. Exceptions and ERET override everything.
//
//  Ports       :
//    clk, reset          clock, synchronous active-high reset
//    id_allowin          ID can accept an instruction this cycle
//    id_is_branch        instruction in ID is a branch/jump (delay-slot tag)
//    npc_redirect        taken branch/jump resolved in ID this cycle
//    npc_target          redirect target
//    exc_req, exc_eret   exception / ERET committed in WB
//    epc                 CP0 EPC (ERET target)
//    inst_sram_*         instruction SRAM port (read-only use)
//    if_valid, if_pc,    IF instruction towards ID and the next-PC
//    if_four_pc, if_inst calculator
//    if_in_ds            IF instruction is a delay slot
//    if_exc, if_execode, instruction-address-error information
//    if_badvaddr
//
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
    parameter logic [4:0]  ADEL_CODE  = 5'h04
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        id_allowin,
    input  logic        id_is_branch,

    input  logic        npc_redirect,
    input  logic [31:0] npc_target,

    input  logic        exc_req,
    input  logic        exc_eret,
    input  logic [31:0] epc,

    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,

    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_four_pc,
    output logic [31:0] if_inst,
    output logic        if_in_ds,
    output logic        if_exc,
    output logic [4:0]  if_execode,
    output logic [31:0] if_badvaddr
);

    localparam logic [31:0] c_PC_STEP = 32'd4;
    localparam logic [31:0] c_NOP     = 32'h0000_0000;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pc_q,        pc_d;
    logic        valid_q,     valid_d;
    logic        br_pend_q,   br_pend_d;
    logic [31:0] br_tgt_q,    br_tgt_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] inst_buf_q,  inst_buf_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic        w_advance;
    logic        w_consume;
    logic        w_exc_any;
    logic        w_fetch_en;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_addr_err;

    // IF may load a new PC when it is empty or ID takes the current one.
    assign w_advance  = !valid_q || id_allowin;
    // A redirect target is only usable once the delay slot (the instruction
    // currently held in IF) is actually leaving.
    assign w_consume  = w_advance && valid_q;
    assign w_exc_any  = exc_req || exc_eret;
    assign w_fetch_en = !reset && (w_exc_any || w_advance);
    assign w_pc_plus4 = pc_q + c_PC_STEP;
    assign w_addr_err = valid_q && (pc_q[1:0] != 2'b00);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (exc_req) begin
            w_next_pc = EXC_VECTOR;
        end else if (exc_eret) begin
            w_next_pc = epc;
        end else if (valid_q && br_pend_q) begin
            w_next_pc = br_tgt_q;
        end else if (valid_q && npc_redirect) begin
            w_next_pc = npc_target;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d        = pc_q;
        valid_d     = valid_q;
        br_pend_d   = br_pend_q;
        br_tgt_d    = br_tgt_q;
        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;

        if (w_fetch_en) begin
            pc_d    = w_next_pc;
            valid_d = 1'b1;
        end

        // Pending branch: remember a redirect that could not be applied yet.
        // A consumed pending target and a same-cycle redirect both clear it,
        // since the redirect was applied directly via next_pc.
        if (w_exc_any) begin
            br_pend_d = 1'b0;
        end else if (w_consume) begin
            br_pend_d = 1'b0;
        end else if (npc_redirect) begin
            br_pend_d = 1'b1;
            br_tgt_d  = npc_target;
        end

        // Instruction buffer: the SRAM only returns data in the cycle after
        // an enabled access, so grab it on the first stalled cycle and hold
        // it until the next fetch replaces the instruction.
        if (w_fetch_en) begin
            buf_valid_d = 1'b0;
        end else if (valid_q && !id_allowin && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC - c_PC_STEP;
            valid_q     <= 1'b0;
            br_pend_q   <= 1'b0;
            br_tgt_q    <= 32'h0000_0000;
            buf_valid_q <= 1'b0;
            inst_buf_q  <= 32'h0000_0000;
        end else begin
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            br_pend_q   <= br_pend_d;
            br_tgt_q    <= br_tgt_d;
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign inst_sram_en    = w_fetch_en;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = w_next_pc;
    assign inst_sram_wdata = 32'h0000_0000;

    assign if_valid    = valid_q;
    assign if_pc       = pc_q;
    assign if_four_pc  = w_pc_plus4;
    assign if_in_ds    = id_is_branch;
    assign if_exc      = w_addr_err;
    assign if_execode  = w_addr_err ? ADEL_CODE : 5'h00;
    assign if_badvaddr = pc_q;
    // A misaligned fetch returns meaningless data; hand ID a nop instead.
    assign if_inst     = w_addr_err  ? c_NOP      :
                         buf_valid_q ? inst_buf_q : inst_sram_rdata;

endmodule
`default_nettype wire
